// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared types and constants for the sequential fp32 multiplier
package fp32_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        NORM,
        ROUND,
        DONE
    } state_t;

    localparam int           BIAS    = 127;
    localparam logic [7:0]   EXP_MAX = 8'hFF;
    localparam logic [31:0]  QNAN    = 32'h7FC00000;
    localparam int           MANT_W  = 23;
    localparam int           EXP_W   = 8;
    localparam int           SIG_W   = MANT_W + 1;
    localparam int           PROD_W  = 2 * SIG_W;
    localparam int           SEXP_W  = 10;
    localparam int           CNT_W   = 5;

endpackage

// File: rtl/fp32_round_pack.sv
// rtl/fp32_round_pack.sv - round-to-nearest-even, classify and pack the product
module fp32_round_pack
    import fp32_pkg::*;
(
    input  logic                sign,
    input  logic [SEXP_W-1:0]   exp_in,
    input  logic [PROD_W-1:0]   prod,
    input  logic                nan_in,
    input  logic                zero_in,
    output logic [31:0]         word,
    output logic                exception,
    output logic                overflow,
    output logic                underflow
);

    logic                guard_bit;
    logic                round_bit;
    logic                sticky_bit;
    logic                round_up;
    logic [SIG_W:0]      sig_rnd;
    logic [SEXP_W-1:0]   exp_rnd;

    // Hidden bit sits at prod[46] after normalisation; prod[47:46] plus the
    // increment tell us whether rounding carried into a new leading bit.
    always_comb begin
        guard_bit  = prod[22];
        round_bit  = prod[21];
        sticky_bit = |prod[20:0];
        round_up   = guard_bit && (round_bit || sticky_bit || prod[23]);
        sig_rnd    = prod[47:23] + {{SIG_W{1'b0}}, round_up};
        exp_rnd    = exp_in + {{(SEXP_W-2){1'b0}}, sig_rnd[SIG_W:SIG_W-1]} - 10'd1;
    end

    // Special operands win, then zero operands, then exponent range checks.
    always_comb begin
        word      = {sign, exp_rnd[EXP_W-1:0], sig_rnd[MANT_W-1:0]};
        exception = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (nan_in) begin
            word      = QNAN;
            exception = 1'b1;
        end else if (zero_in) begin
            word      = {sign, 31'b0};
        end else if ($signed(exp_rnd) >= $signed(10'd255)) begin
            word      = {sign, EXP_MAX, {MANT_W{1'b0}}};
            overflow  = 1'b1;
        end else if ($signed(exp_rnd) <= $signed(10'd0)) begin
            word      = {sign, 31'b0};
            underflow = 1'b1;
        end
    end

endmodule

// File: rtl/fp32_mul_seq.sv
// rtl/fp32_mul_seq.sv - fixed-latency shift-add IEEE-754 single multiplier
module fp32_mul_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);

    state_t              state, state_nxt;
    logic                sign_q;
    logic [SEXP_W-1:0]   exp_q;
    logic [SIG_W-1:0]    ma_q, mb_q;
    logic                nan_q, zero_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   prod_q;
    logic [31:0]         rp_word;
    logic                rp_exc, rp_ovf, rp_unf;
    logic                accept;
    logic [EXP_W-1:0]    ea, eb;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign ea        = a_in[30:23];
    assign eb        = b_in[30:23];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: 24 multiply steps, one normalise, one round, then hold.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid)              state_nxt = MULT;
            MULT:  if (cnt_q == CNT_W'(23))   state_nxt = NORM;
            NORM:                             state_nxt = ROUND;
            ROUND:                            state_nxt = DONE;
            DONE:  if (out_ready)             state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Operand capture, shift-add multiply, normalise and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q    <= 1'b0;
            exp_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            nan_q     <= 1'b0;
            zero_q    <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
            result    <= '0;
            Exception <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sign_q <= a_in[31] ^ b_in[31];
                    exp_q  <= {2'b00, ea} + {2'b00, eb} - SEXP_W'(BIAS);
                    ma_q   <= {(ea != '0), a_in[MANT_W-1:0]};
                    mb_q   <= {(eb != '0), b_in[MANT_W-1:0]};
                    nan_q  <= (ea == EXP_MAX) || (eb == EXP_MAX);
                    zero_q <= (ea == '0) || (eb == '0);
                    cnt_q  <= '0;
                    prod_q <= '0;
                end
                MULT: begin
                    if (mb_q[cnt_q])
                        prod_q <= prod_q + ({{SIG_W{1'b0}}, ma_q} << cnt_q);
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                NORM: if (prod_q[PROD_W-1]) begin
                    prod_q <= prod_q >> 1;
                    exp_q  <= exp_q + SEXP_W'(1);
                end
                ROUND: begin
                    result    <= rp_word;
                    Exception <= rp_exc;
                    Overflow  <= rp_ovf;
                    Underflow <= rp_unf;
                end
                DONE: if (out_ready) begin
                    Exception <= 1'b0;
                    Overflow  <= 1'b0;
                    Underflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    fp32_round_pack u_round_pack (
        .sign      (sign_q),
        .exp_in    (exp_q),
        .prod      (prod_q),
        .nan_in    (nan_q),
        .zero_in   (zero_q),
        .word      (rp_word),
        .exception (rp_exc),
        .overflow  (rp_ovf),
        .underflow (rp_unf)
    );

endmodule

// File: tb/tb_fp32_mul_seq.sv
// tb/tb_fp32_mul_seq.sv - scoreboard bench for fp32_mul_seq
module tb_fp32_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        Exception, Overflow, Underflow;

    typedef struct {
        logic [31:0] r;
        logic        e;
        logic        o;
        logic        u;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        held = 1'b0;
    logic [31:0] held_r;
    logic [2:0]  held_f;

    fp32_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Exception (Exception),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on the first cycle of each result.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                chk("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
                if (!held) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("result", result, e.r);
                        chk("flags", {29'b0, Exception, Overflow, Underflow},
                            {29'b0, e.e, e.o, e.u});
                        chk("latency", cyc - e.acc, 32'd26);
                    end
                    held   = 1'b1;
                    held_r = result;
                    held_f = {Exception, Overflow, Underflow};
                end else begin
                    chk("hold_result", result, held_r);
                    chk("hold_flags", {29'b0, Exception, Overflow, Underflow}, {29'b0, held_f});
                end
                if (out_ready) held = 1'b0;
            end else begin
                held = 1'b0;
                chk("flags_idle_zero", {29'b0, Exception, Overflow, Underflow}, 32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input logic e, input logic o, input logic u);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'd0, 32'd1);
        end else begin
            a_in     = a;
            b_in     = b;
            in_valid = 1'b1;
            sb.push_back('{r, e, o, u, cyc + 1});
            @(negedge clk);
            in_valid = 1'b0;
            a_in     = $urandom;
            b_in     = $urandom;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_result", result, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_flags", {29'b0, Exception, Overflow, Underflow}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        issue(32'h40400000, 32'h40A00000, 32'h41700000, 0, 0, 0);
        issue(32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0);
        issue(32'h3F800000, 32'hC0000000, 32'hC0000000, 0, 0, 0);
        issue(32'h7F000000, 32'h40000000, 32'h7F800000, 0, 1, 0);
        issue(32'h00800000, 32'h00800000, 32'h00000000, 0, 0, 1);
        issue(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1, 0, 0);
        issue(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0, 0, 0);
        issue(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 0, 0, 0);
        issue(32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 0, 1, 0);
        issue(32'h3F800000, 32'h00800000, 32'h00800000, 0, 0, 0);
        issue(32'h7F800000, 32'h00000000, 32'h7FC00000, 1, 0, 0);
        issue(32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 0, 0, 0);
        drain();

        // Back-pressure: hold out_ready low for 5 cycles of DONE.
        out_ready = 1'b0;
        issue(32'h00000000, 32'hC1200000, 32'h80000000, 0, 0, 0);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("hold_wait_valid", {31'b0, out_valid}, 32'd1);
        end
        repeat (5) @(negedge clk);
        chk("hold_still_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        drain();

        // Abort with reset during MULT iteration 10.
        @(negedge clk);
        a_in     = 32'h40400000;
        b_in     = 32'h40A00000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (30) @(negedge clk);
        issue(32'h40400000, 32'h40A00000, 32'h41700000, 0, 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
